// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//
// Purpose:
//   APB master that shares one APB bus between NUM_OF_REQUESTERS on-chip
//   requesters. A combinational round-robin arbiter picks one request at a
//   time. The FSM (IDLE/WAKE/SETUP/ACCESS/BADSEL) drives PWAKEUP and the
//   SETUP/ACCESS phases. It returns read data, error and timeout status to
//   the requester that owns the transfer.
//
// Ports:
//   PCLK, PRESET          clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready combinational)
//   req_write/addr/wdata/strb/prot/slave
//                         flattened per-requester request fields
//   rsp_valid             one-cycle response pulse to the owning requester
//   rsp_rdata/error/timeout
//                         shared response fields, held between pulses
//   PADDR..PWAKEUP        APB master outputs (all registered)
//   PREADY/PRDATA/PSLVERR APB slave responses
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_OF_SLAVES     = 4,
    parameter int NUM_OF_REQUESTERS = 4,
    parameter int WAKEUP_LEAD       = 1,
    parameter int TIMEOUT_CYCLES    = 16,
    localparam int SW  = (NUM_OF_SLAVES > 1) ? $clog2(NUM_OF_SLAVES) : 1,
    localparam int SBW = DATA_WIDTH / 8
) (
    input  logic                                    PCLK,
    input  logic                                    PRESET,
    input  logic [NUM_OF_REQUESTERS-1:0]            req_valid,
    output logic [NUM_OF_REQUESTERS-1:0]            req_ready,
    input  logic [NUM_OF_REQUESTERS-1:0]            req_write,
    input  logic [NUM_OF_REQUESTERS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_OF_REQUESTERS*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_OF_REQUESTERS*SBW-1:0]        req_strb,
    input  logic [NUM_OF_REQUESTERS*3-1:0]          req_prot,
    input  logic [NUM_OF_REQUESTERS*SW-1:0]         req_slave,
    output logic [NUM_OF_REQUESTERS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]                   rsp_rdata,
    output logic                                    rsp_error,
    output logic                                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]                   PADDR,
    output logic [2:0]                              PPROT,
    output logic [NUM_OF_SLAVES-1:0]                PSELx,
    output logic                                    PENABLE,
    output logic                                    PWRITE,
    output logic [DATA_WIDTH-1:0]                   PWDATA,
    output logic [SBW-1:0]                          PSTRB,
    output logic                                    PWAKEUP,
    input  logic                                    PREADY,
    input  logic [DATA_WIDTH-1:0]                   PRDATA,
    input  logic                                    PSLVERR
);

    localparam int N   = NUM_OF_REQUESTERS;
    localparam int RW  = (N > 1) ? $clog2(N) : 1;
    localparam int WCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST   = WCW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [3:0]     WAKE_INIT   = 4'((WAKEUP_LEAD > 0) ? WAKEUP_LEAD - 1 : 0);
    localparam logic [SW:0]    SLAVE_LIMIT = (SW + 1)'(NUM_OF_SLAVES);
    localparam logic [RW:0]    N_WIDE      = (RW + 1)'(N);
    localparam logic [RW-1:0]  LAST_REQ    = RW'(N - 1);

    typedef enum logic [2:0] {IDLE, WAKE, SETUP, ACCESS, BADSEL} state_t;

    state_t                  state_reg;
    logic [RW-1:0]           ptr_reg;
    logic [RW-1:0]           owner_reg;
    logic [3:0]              wake_cnt_reg;
    logic [WCW-1:0]          wait_cnt_reg;
    logic [ADDR_WIDTH-1:0]   cap_addr_reg;
    logic [DATA_WIDTH-1:0]   cap_wdata_reg;
    logic [SBW-1:0]          cap_strb_reg;
    logic [2:0]              cap_prot_reg;
    logic [SW-1:0]           cap_slave_reg;
    logic                    cap_write_reg;

    // Per-requester views of the flattened request buses
    logic [ADDR_WIDTH-1:0]   addr_arr  [N];
    logic [DATA_WIDTH-1:0]   wdata_arr [N];
    logic [SBW-1:0]          strb_arr  [N];
    logic [2:0]              prot_arr  [N];
    logic [SW-1:0]           slave_arr [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign strb_arr[gi]  = req_strb[gi*SBW +: SBW];
            assign prot_arr[gi]  = req_prot[gi*3 +: 3];
            assign slave_arr[gi] = req_slave[gi*SW +: SW];
        end
    endgenerate

    // Round-robin: rotate the valid vector so the pointer lands on bit 0,
    // take the lowest set bit, then rotate the offset back.
    logic [2*N-1:0] valid_dbl;
    logic [N-1:0]   valid_rot;
    logic           grant_found;
    logic [RW-1:0]  grant_off;
    logic [RW:0]    grant_sum;
    logic [RW-1:0]  grant_idx;

    assign valid_dbl = {req_valid, req_valid};
    assign valid_rot = N'(valid_dbl >> ptr_reg);

    always_comb begin
        grant_found = 1'b0;
        grant_off   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (valid_rot[j]) begin
                grant_found = 1'b1;
                grant_off   = RW'(j);
            end
        end
        grant_sum = {1'b0, ptr_reg} + {1'b0, grant_off};
        if (grant_sum >= N_WIDE) begin
            grant_sum = grant_sum - N_WIDE;
        end
        grant_idx = grant_sum[RW-1:0];
    end

    // Timeout fires on the last permitted wait cycle, so no accept can
    // coincide with it (PREADY is low).
    logic timeout_hit;
    logic accept_window;
    logic accept;

    assign timeout_hit   = (TIMEOUT_CYCLES > 0) && (state_reg == ACCESS) && !PREADY
                           && (wait_cnt_reg == WAIT_LAST);
    assign accept_window = (state_reg == IDLE) || ((state_reg == ACCESS) && PREADY);
    assign accept        = accept_window && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Winner fields and the slave-index range check
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [SBW-1:0]        win_strb;
    logic [2:0]            win_prot;
    logic [SW-1:0]         win_slave;
    logic                  win_write;
    logic                  win_bad;

    assign win_addr  = addr_arr[grant_idx];
    assign win_wdata = wdata_arr[grant_idx];
    assign win_strb  = strb_arr[grant_idx];
    assign win_prot  = prot_arr[grant_idx];
    assign win_slave = slave_arr[grant_idx];
    assign win_write = req_write[grant_idx];
    assign win_bad   = ({1'b0, win_slave} >= SLAVE_LIMIT);

    // SETUP is entered either on an accept edge (take the winner directly)
    // or out of WAKE (take the captured copy).
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic [SBW-1:0]        ld_strb;
    logic [2:0]            ld_prot;
    logic [SW-1:0]         ld_slave;
    logic                  ld_write;
    logic                  go_setup;

    always_comb begin
        ld_addr  = accept ? win_addr  : cap_addr_reg;
        ld_wdata = accept ? win_wdata : cap_wdata_reg;
        ld_strb  = accept ? win_strb  : cap_strb_reg;
        ld_prot  = accept ? win_prot  : cap_prot_reg;
        ld_slave = accept ? win_slave : cap_slave_reg;
        ld_write = accept ? win_write : cap_write_reg;
        go_setup = 1'b0;
        case (state_reg)
            IDLE:    go_setup = accept && !win_bad && (WAKEUP_LEAD == 0);
            WAKE:    go_setup = (wake_cnt_reg == 4'd0);
            ACCESS:  go_setup = accept && !win_bad;
            default: go_setup = 1'b0;
        endcase
    end

    function automatic logic [NUM_OF_SLAVES-1:0] slave_onehot(input logic [SW-1:0] s);
        slave_onehot = '0;
        for (int k = 0; k < NUM_OF_SLAVES; k++) begin
            slave_onehot[k] = (s == SW'(k));
        end
    endfunction

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            wake_cnt_reg  <= '0;
            wait_cnt_reg  <= '0;
            cap_addr_reg  <= '0;
            cap_wdata_reg <= '0;
            cap_strb_reg  <= '0;
            cap_prot_reg  <= '0;
            cap_slave_reg <= '0;
            cap_write_reg <= 1'b0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_error     <= 1'b0;
            rsp_timeout   <= 1'b0;
            PADDR         <= '0;
            PPROT         <= '0;
            PSELx         <= '0;
            PENABLE       <= 1'b0;
            PWRITE        <= 1'b0;
            PWDATA        <= '0;
            PSTRB         <= '0;
            PWAKEUP       <= 1'b0;
        end else begin
            rsp_valid <= '0;

            if (accept) begin
                ptr_reg       <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
                owner_reg     <= grant_idx;
                cap_addr_reg  <= win_addr;
                cap_wdata_reg <= win_wdata;
                cap_strb_reg  <= win_strb;
                cap_prot_reg  <= win_prot;
                cap_slave_reg <= win_slave;
                cap_write_reg <= win_write;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (win_bad) begin
                            state_reg <= BADSEL;
                        end else begin
                            PWAKEUP <= 1'b1;
                            if (WAKEUP_LEAD > 0) begin
                                state_reg    <= WAKE;
                                wake_cnt_reg <= WAKE_INIT;
                            end else begin
                                state_reg <= SETUP;
                            end
                        end
                    end
                end
                WAKE: begin
                    if (wake_cnt_reg == 4'd0) begin
                        state_reg <= SETUP;
                    end else begin
                        wake_cnt_reg <= wake_cnt_reg - 4'd1;
                    end
                end
                SETUP: begin
                    state_reg    <= ACCESS;
                    PENABLE      <= 1'b1;
                    wait_cnt_reg <= '0;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid[owner_reg] <= 1'b1;
                        rsp_rdata            <= (PWRITE || PSLVERR) ? '0 : PRDATA;
                        rsp_error            <= PSLVERR;
                        rsp_timeout          <= 1'b0;
                        PENABLE              <= 1'b0;
                        if (accept) begin
                            // Back-to-back: PWAKEUP stays high, no WAKE
                            if (win_bad) begin
                                state_reg <= BADSEL;
                                PSELx     <= '0;
                            end else begin
                                state_reg <= SETUP;
                            end
                        end else begin
                            state_reg <= IDLE;
                            PSELx     <= '0;
                            PWAKEUP   <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        rsp_valid[owner_reg] <= 1'b1;
                        rsp_rdata            <= '0;
                        rsp_error            <= 1'b1;
                        rsp_timeout          <= 1'b1;
                        state_reg            <= IDLE;
                        PSELx                <= '0;
                        PENABLE              <= 1'b0;
                        PWAKEUP              <= 1'b0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                BADSEL: begin
                    rsp_valid[owner_reg] <= 1'b1;
                    rsp_rdata            <= '0;
                    rsp_error            <= 1'b1;
                    rsp_timeout          <= 1'b0;
                    state_reg            <= IDLE;
                    PSELx                <= '0;
                    PENABLE              <= 1'b0;
                    PWAKEUP              <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase

            if (go_setup) begin
                PADDR  <= ld_addr;
                PPROT  <= ld_prot;
                PWRITE <= ld_write;
                PWDATA <= ld_write ? ld_wdata : '0;
                PSTRB  <= ld_write ? ld_strb : '0;
                PSELx  <= slave_onehot(ld_slave);
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arbiter
//
// Directed bench for apb_master_arbiter (4 requesters, 3 slaves so that
// slave index 3 is out of range, WAKEUP_LEAD=1, TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled on the falling edge of PCLK.
// ---------------------------------------------------------------------------
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_apb_master_arbiter;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NS  = 3;
    localparam int SW  = 2;
    localparam int SBW = 4;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [N-1:0]      req_valid, req_ready, req_write, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SBW-1:0]  req_strb;
    logic [N*3-1:0]    req_prot;
    logic [N*SW-1:0]   req_slave;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_error, rsp_timeout;
    logic [AW-1:0]     PADDR;
    logic [2:0]        PPROT;
    logic [NS-1:0]     PSELx;
    logic              PENABLE, PWRITE, PWAKEUP, PREADY, PSLVERR;
    logic [DW-1:0]     PWDATA, PRDATA;
    logic [SBW-1:0]    PSTRB;

    int errors = 0;
    int checks = 0;

    apb_master_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_OF_SLAVES(NS),
        .NUM_OF_REQUESTERS(N), .WAKEUP_LEAD(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .req_slave(req_slave),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PWAKEUP(PWAKEUP),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SBW-1:0] s,
                           input logic [2:0] p, input logic [SW-1:0] sl);
        req_write[i]              = wr;
        req_addr[i*AW +: AW]      = a;
        req_wdata[i*DW +: DW]     = d;
        req_strb[i*SBW +: SBW]    = s;
        req_prot[i*3 +: 3]        = p;
        req_slave[i*SW +: SW]     = sl;
        req_valid[i]              = 1'b1;
    endtask

    initial begin
        logic [NS-1:0] exp_sel;
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  exp_rsp;
        int g;

        PRESET = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0; req_slave = '0;
        PREADY = 1'b1; PRDATA = 32'hDEADBEEF; PSLVERR = 1'b0;

        // Reset state
        #2;
        `CHK("reset PSELx", PSELx, 3'b000)
        `CHK("reset PWAKEUP", PWAKEUP, 1'b0)
        `CHK("reset rsp_valid", rsp_valid, 4'b0000)
        @(negedge PCLK);
        PRESET = 1'b0;

        // ---- Single read, requester 0, slave 1, PRDATA=DEADBEEF ----
        @(negedge PCLK);
        set_req(0, 1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF, 3'b010, 2'd1);
        #1 `CHK("rd ready", req_ready, 4'b0001)
        @(negedge PCLK);
        req_valid = '0;
        `CHK("rd wake PWAKEUP", PWAKEUP, 1'b1)
        `CHK("rd wake PSELx", PSELx, 3'b000)
        @(negedge PCLK);
        `CHK("rd setup PSELx", PSELx, 3'b010)
        `CHK("rd setup PENABLE", PENABLE, 1'b0)
        `CHK("rd setup PADDR", PADDR, 32'h10)
        `CHK("rd setup PWRITE", PWRITE, 1'b0)
        `CHK("rd setup PSTRB", PSTRB, 4'h0)
        `CHK("rd setup PWDATA", PWDATA, 32'h0)
        `CHK("rd setup PPROT", PPROT, 3'b010)
        @(negedge PCLK);
        `CHK("rd access PENABLE", PENABLE, 1'b1)
        `CHK("rd access rsp_valid", rsp_valid, 4'b0000)
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 4'b0001) begin
            errors++;
            $error("FAIL rd rsp_valid: observed=%0h expected=1", rsp_valid);
        end
        checks++;
        if (rsp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $error("FAIL rd rsp_rdata: observed=%0h expected=deadbeef", rsp_rdata);
        end
        `CHK("rd rsp_error", rsp_error, 1'b0)
        `CHK("rd idle PSELx", PSELx, 3'b000)
        `CHK("rd idle PWAKEUP", PWAKEUP, 1'b0)
        $display("TXN read req0 addr=10 rdata=%0h error=%0b", rsp_rdata, rsp_error);
        @(negedge PCLK);
        `CHK("rd pulse end", rsp_valid, 4'b0000)
        `CHK("rd rdata hold", rsp_rdata, 32'hDEADBEEF)

        // ---- Back-to-back writes from all 4 requesters, after reset ----
        @(negedge PCLK);
        #2 PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b1, 32'(32'h100 + 4 * i), 32'(32'hA000_0000 + i), 4'hF,
                    3'(i), 2'(i % 3));
        end
        #1 `CHK("b2b first ready", req_ready, 4'b0001)
        @(negedge PCLK);
        `CHK("b2b wake ready", req_ready, 4'b0000)
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            exp_sel = 3'b001 << (g % 3);
            @(negedge PCLK);
            checks++;
            if (PSELx !== exp_sel) begin
                errors++;
                $error("FAIL b2b setup PSELx: observed=%0h expected=%0h", PSELx, exp_sel);
            end
            checks++;
            if (PENABLE !== 1'b0) begin
                errors++;
                $error("FAIL b2b setup PENABLE: observed=%0h expected=0", PENABLE);
            end
            checks++;
            if (PWAKEUP !== 1'b1) begin
                errors++;
                $error("FAIL b2b PWAKEUP: observed=%0h expected=1", PWAKEUP);
            end
            `CHK("b2b setup PADDR", PADDR, 32'(32'h100 + 4 * g))
            `CHK("b2b setup PWDATA", PWDATA, 32'(32'hA000_0000 + g))
            if (k > 0) begin
                exp_rsp = 4'b0001 << ((g + 3) % 4);
                `CHK("b2b rsp_valid", rsp_valid, exp_rsp)
            end
            $display("TXN b2b write grant=%0d PADDR=%0h PSELx=%0b", g, PADDR, PSELx);
            if (k == 4) req_valid = '0;
            @(negedge PCLK);
            `CHK("b2b access PENABLE", PENABLE, 1'b1)
            exp_rdy = (k < 4) ? (4'b0001 << ((g + 1) % 4)) : 4'b0000;
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $error("FAIL b2b grant: observed=%0h expected=%0h", req_ready, exp_rdy);
            end
        end
        @(negedge PCLK);
        `CHK("b2b last rsp_valid", rsp_valid, 4'b0001)
        `CHK("b2b write rdata", rsp_rdata, 32'h0)
        `CHK("b2b idle PSELx", PSELx, 3'b000)
        `CHK("b2b idle PWAKEUP", PWAKEUP, 1'b0)

        // ---- Write with 5 wait states then PSLVERR (requester 1) ----
        @(negedge PCLK);
        set_req(1, 1'b1, 32'h200, 32'h1234_5678, 4'b0101, 3'b101, 2'd2);
        PREADY = 1'b0;
        @(negedge PCLK);
        req_valid = '0;
        @(negedge PCLK);
        `CHK("ws setup PSELx", PSELx, 3'b100)
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            checks++;
            if (PENABLE !== 1'b1) begin
                errors++;
                $error("FAIL ws PENABLE: observed=%0h expected=1", PENABLE);
            end
            checks++;
            if (PSELx !== 3'b100) begin
                errors++;
                $error("FAIL ws PSELx: observed=%0h expected=4", PSELx);
            end
            checks++;
            if (PADDR !== 32'h200) begin
                errors++;
                $error("FAIL ws PADDR: observed=%0h expected=200", PADDR);
            end
            `CHK("ws PWDATA", PWDATA, 32'h1234_5678)
            `CHK("ws PSTRB", PSTRB, 4'b0101)
            `CHK("ws PPROT", PPROT, 3'b101)
            `CHK("ws rsp_valid", rsp_valid, 4'b0000)
        end
        @(negedge PCLK);
        `CHK("ws last PENABLE", PENABLE, 1'b1)
        PREADY = 1'b1;
        PSLVERR = 1'b1;
        @(negedge PCLK);
        PSLVERR = 1'b0;
        checks++;
        if (rsp_valid !== 4'b0010) begin
            errors++;
            $error("FAIL ws rsp_valid: observed=%0h expected=2", rsp_valid);
        end
        checks++;
        if (rsp_error !== 1'b1) begin
            errors++;
            $error("FAIL ws rsp_error: observed=%0h expected=1", rsp_error);
        end
        `CHK("ws rsp_timeout", rsp_timeout, 1'b0)
        `CHK("ws rsp_rdata", rsp_rdata, 32'h0)
        $display("TXN write req1 addr=200 error=%0b timeout=%0b", rsp_error, rsp_timeout);

        // ---- Timeout: PREADY held low (requester 2, read) ----
        @(negedge PCLK);
        set_req(2, 1'b0, 32'h300, 32'h0, 4'h0, 3'b000, 2'd0);
        PREADY = 1'b0;
        @(negedge PCLK);
        req_valid = '0;
        @(negedge PCLK);
        `CHK("to setup PSELx", PSELx, 3'b001)
        for (int i = 0; i < 16; i++) begin
            @(negedge PCLK);
            checks++;
            if ({PENABLE, rsp_valid} !== 5'b1_0000) begin
                errors++;
                $error("FAIL to waiting: observed=%0h expected=10", {PENABLE, rsp_valid});
            end
        end
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 4'b0100) begin
            errors++;
            $error("FAIL to rsp_valid: observed=%0h expected=4", rsp_valid);
        end
        checks++;
        if (rsp_timeout !== 1'b1) begin
            errors++;
            $error("FAIL to rsp_timeout: observed=%0h expected=1", rsp_timeout);
        end
        `CHK("to rsp_error", rsp_error, 1'b1)
        `CHK("to rsp_rdata", rsp_rdata, 32'h0)
        `CHK("to PSELx", PSELx, 3'b000)
        `CHK("to PENABLE", PENABLE, 1'b0)
        $display("TXN read req2 addr=300 error=%0b timeout=%0b", rsp_error, rsp_timeout);
        PREADY = 1'b1;

        // ---- Bad slave index 3 (requester 3) ----
        @(negedge PCLK);
        set_req(3, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000, 2'd3);
        #1 `CHK("bad ready", req_ready, 4'b1000)
        @(negedge PCLK);
        req_valid = '0;
        `CHK("bad PSELx", PSELx, 3'b000)
        `CHK("bad no rsp yet", rsp_valid, 4'b0000)
        `CHK("bad PWAKEUP", PWAKEUP, 1'b0)
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 4'b1000) begin
            errors++;
            $error("FAIL bad rsp_valid: observed=%0h expected=8", rsp_valid);
        end
        `CHK("bad rsp_error", rsp_error, 1'b1)
        `CHK("bad rsp_timeout", rsp_timeout, 1'b0)
        `CHK("bad PSELx after", PSELx, 3'b000)
        $display("TXN badsel req3 slave=3 error=%0b", rsp_error);

        // ---- Reset in the middle of ACCESS (requester 1) ----
        @(negedge PCLK);
        set_req(1, 1'b1, 32'h500, 32'h5555_AAAA, 4'hF, 3'b001, 2'd1);
        PREADY = 1'b0;
        #1 `CHK("rst ready", req_ready, 4'b0010)
        @(negedge PCLK);
        req_valid = '0;
        @(negedge PCLK);
        @(negedge PCLK);
        `CHK("rst access PENABLE", PENABLE, 1'b1)
        #2 PRESET = 1'b1;
        #1;
        checks++;
        if (PSELx !== 3'b000) begin
            errors++;
            $error("FAIL rst async PSELx: observed=%0h expected=0", PSELx);
        end
        `CHK("rst async PENABLE", PENABLE, 1'b0)
        `CHK("rst async PWAKEUP", PWAKEUP, 1'b0)
        `CHK("rst async PADDR", PADDR, 32'h0)
        `CHK("rst async PWRITE", PWRITE, 1'b0)
        `CHK("rst async rsp_error", rsp_error, 1'b0)
        `CHK("rst async rsp_valid", rsp_valid, 4'b0000)
        PREADY = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        `CHK("rst no response", rsp_valid, 4'b0000)
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, 32'h600, 32'h0, 4'h0, 3'b000, 2'd0);
        end
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $error("FAIL rst ptr cleared: observed=%0h expected=1", req_ready);
        end
        $display("TXN reset-abort req1 addr=500 next grant ready=%0b", req_ready);
        @(negedge PCLK);
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
